// File: rtl/mem_request_port.sv
// Request-side front end for interleaved_memory: decodes load/store funct3, range-checks the
// access, drives the memory for one cycle and returns results through an in-order response FIFO.
module mem_request_port #(
    parameter int MEMORY_DEPTH_BYTES = 1024,
    parameter int RSP_DEPTH          = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  req_valid_i,
    output logic                                  req_ready_o,
    input  logic [$clog2(MEMORY_DEPTH_BYTES)-1:0] req_addr_i,
    input  logic                                  req_we_i,
    input  logic [2:0]                            req_funct3_i,
    input  logic [31:0]                           req_wdata_i,
    output logic                                  rsp_valid_o,
    input  logic                                  rsp_ready_i,
    output logic [31:0]                           rsp_rdata_o,
    output logic [1:0]                            rsp_err_o,
    output logic [1:0]                            mem_width_o,
    output logic                                  mem_sign_extend_o,
    output logic [$clog2(MEMORY_DEPTH_BYTES)-1:0] mem_addr_o,
    output logic [31:0]                           mem_data_o,
    output logic                                  mem_write_enable_o,
    input  logic [31:0]                           mem_data_i
);
    localparam int AddrWidth = $clog2(MEMORY_DEPTH_BYTES);
    localparam int PtrWidth  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CntWidth  = $clog2(RSP_DEPTH + 1);

    localparam logic [1:0] WIDTH_BYTE = 2'd0;
    localparam logic [1:0] WIDTH_HALF = 2'd1;
    localparam logic [1:0] WIDTH_WORD = 2'd2;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_FUNCT3 = 2'b01;
    localparam logic [1:0] ERR_RANGE  = 2'b10;

    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] ptr);
        if (ptr == PtrWidth'(RSP_DEPTH - 1)) begin
            return '0;
        end
        return ptr + PtrWidth'(1);
    endfunction

    logic [1:0]           dec_width;
    logic                 dec_sign;
    logic                 dec_legal;
    logic [2:0]           dec_bytes;
    logic [AddrWidth:0]   end_addr;
    logic                 range_err;
    logic [1:0]           req_err;
    logic                 accept;

    always_comb begin
        dec_width = WIDTH_WORD;
        dec_sign  = 1'b0;
        dec_legal = 1'b0;
        dec_bytes = 3'd4;
        case (req_funct3_i)
            3'b000: begin
                dec_width = WIDTH_BYTE;
                dec_bytes = 3'd1;
                dec_sign  = !req_we_i;
                dec_legal = 1'b1;
            end
            3'b001: begin
                dec_width = WIDTH_HALF;
                dec_bytes = 3'd2;
                dec_sign  = !req_we_i;
                dec_legal = 1'b1;
            end
            3'b010: begin
                dec_width = WIDTH_WORD;
                dec_bytes = 3'd4;
                dec_legal = 1'b1;
            end
            3'b100: begin
                dec_width = WIDTH_BYTE;
                dec_bytes = 3'd1;
                dec_legal = !req_we_i;
            end
            3'b101: begin
                dec_width = WIDTH_HALF;
                dec_bytes = 3'd2;
                dec_legal = !req_we_i;
            end
            default: begin
                dec_legal = 1'b0;
            end
        endcase
    end

    // The extra top bit of end_addr catches accesses that would wrap past the last byte.
    assign end_addr  = {1'b0, req_addr_i} + (AddrWidth + 1)'(dec_bytes) - (AddrWidth + 1)'(1);
    assign range_err = end_addr[AddrWidth];
    assign req_err   = !dec_legal ? ERR_FUNCT3 : (range_err ? ERR_RANGE : ERR_NONE);

    logic                 inflight_vld_p1;
    logic                 inflight_load_p1;
    logic [1:0]           inflight_err_p1;
    logic [PtrWidth-1:0]  wr_ptr;
    logic [PtrWidth-1:0]  rd_ptr;
    logic [CntWidth-1:0]  count;
    logic [31:0]          fifo_rdata [RSP_DEPTH];
    logic [1:0]           fifo_err   [RSP_DEPTH];
    logic                 push;
    logic                 pop;
    logic [31:0]          push_rdata;

    assign req_ready_o = !rst_i &&
        (({1'b0, count} + (CntWidth + 1)'(inflight_vld_p1)) < (CntWidth + 1)'(RSP_DEPTH));
    assign accept      = req_valid_i & req_ready_o;

    assign mem_addr_o         = req_addr_i;
    assign mem_data_o         = req_wdata_i;
    assign mem_width_o        = dec_width;
    assign mem_sign_extend_o  = dec_sign;
    assign mem_write_enable_o = accept & req_we_i & (req_err == ERR_NONE);

    // Stage p0 -> p1: remember what the memory is serving this cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight_vld_p1 <= 1'b0;
        end else begin
            inflight_vld_p1 <= accept;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            inflight_load_p1 <= !req_we_i;
            inflight_err_p1  <= req_err;
        end
    end

    // Stage p1 -> FIFO: memory read data is valid now and is captured into the response queue.
    assign push       = inflight_vld_p1;
    assign push_rdata = (inflight_load_p1 && inflight_err_p1 == ERR_NONE) ? mem_data_i : 32'd0;
    assign pop        = rsp_valid_o & rsp_ready_i;

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_rdata[wr_ptr] <= push_rdata;
            fifo_err[wr_ptr]   <= inflight_err_p1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CntWidth'(1);
                2'b01:   count <= count - CntWidth'(1);
                default: count <= count;
            endcase
        end
    end

    assign rsp_valid_o = !rst_i && (count != '0);
    assign rsp_rdata_o = rsp_valid_o ? fifo_rdata[rd_ptr] : 32'd0;
    assign rsp_err_o   = rsp_valid_o ? fifo_err[rd_ptr] : 2'b00;

endmodule

// File: tb/tb_mem_request_port.sv
// Directed bench for mem_request_port with a little-endian byte-array model of interleaved_memory
// (registered read, sign/zero extension done inside the memory).
module tb_mem_request_port;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [9:0]  req_addr;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic [1:0]  mem_width;
    logic        mem_sign_extend;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write_enable;
    logic [31:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;
    int accepts;
    logic [31:0] words [4];

    logic [7:0] mem [1024];

    always #5 clk = ~clk;

    mem_request_port #(.MEMORY_DEPTH_BYTES(1024), .RSP_DEPTH(4)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .req_valid_i        (req_valid),
        .req_ready_o        (req_ready),
        .req_addr_i         (req_addr),
        .req_we_i           (req_we),
        .req_funct3_i       (req_funct3),
        .req_wdata_i        (req_wdata),
        .rsp_valid_o        (rsp_valid),
        .rsp_ready_i        (rsp_ready),
        .rsp_rdata_o        (rsp_rdata),
        .rsp_err_o          (rsp_err),
        .mem_width_o        (mem_width),
        .mem_sign_extend_o  (mem_sign_extend),
        .mem_addr_o         (mem_addr),
        .mem_data_o         (mem_wdata),
        .mem_write_enable_o (mem_write_enable),
        .mem_data_i         (mem_rdata)
    );

    function automatic logic [31:0] mem_read(input logic [9:0] a, input logic [1:0] w, input logic s);
        logic [31:0] v;
        v = {mem[a + 10'd3], mem[a + 10'd2], mem[a + 10'd1], mem[a]};
        case (w)
            2'd0:    return s ? {{24{v[7]}}, v[7:0]} : {24'd0, v[7:0]};
            2'd1:    return s ? {{16{v[15]}}, v[15:0]} : {16'd0, v[15:0]};
            default: return v;
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_write_enable) begin
            mem[mem_addr] <= mem_wdata[7:0];
            if (mem_width != 2'd0) mem[mem_addr + 10'd1] <= mem_wdata[15:8];
            if (mem_width == 2'd2) begin
                mem[mem_addr + 10'd2] <= mem_wdata[23:16];
                mem[mem_addr + 10'd3] <= mem_wdata[31:24];
            end
        end
        mem_rdata <= mem_read(mem_addr, mem_width, mem_sign_extend);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One isolated request with rsp_ready high: response must appear exactly two cycles later.
    task automatic single(input string tag, input logic we, input logic [2:0] f3, input logic [9:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic [1:0] exp_err);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        #1;
        chk({tag, " ready"}, 32'(req_ready), 32'd1);
        chk({tag, " mem_we"}, 32'(mem_write_enable), 32'(we && exp_err == 2'b00));
        tick();
        req_valid = 1'b0;
        chk({tag, " valid_n1"}, 32'(rsp_valid), 32'd0);
        tick();
        chk({tag, " valid_n2"}, 32'(rsp_valid), 32'd1);
        chk({tag, " rdata"}, rsp_rdata, exp_rdata);
        chk({tag, " err"}, 32'(rsp_err), 32'(exp_err));
        tick();
        chk({tag, " drained"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'd0;
        words[0] = 32'h8000_0001;
        words[1] = 32'h1234_5678;
        words[2] = 32'h0F0F_F0F0;
        words[3] = 32'hA5A5_5A5A;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b0;
        tick();
        tick();
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 10'h000;
        req_wdata  = 32'hFFFF_FFFF;
        #1;
        chk("reset ready", 32'(req_ready), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rdata", rsp_rdata, 32'd0);
        chk("reset err", 32'(rsp_err), 32'd0);
        chk("reset mem_we", 32'(mem_write_enable), 32'd0);
        tick();
        req_valid = 1'b0;
        rst       = 1'b0;
        #1;
        chk("post reset ready", 32'(req_ready), 32'd1);
        rsp_ready = 1'b1;
        tick();

        single("sw5",   1'b1, 3'b010, 10'h005, 32'hDEAD_BEEF, 32'h0000_0000, 2'b00);
        single("lw5",   1'b0, 3'b010, 10'h005, 32'h0,         32'hDEAD_BEEF, 2'b00);
        single("lb6",   1'b0, 3'b000, 10'h006, 32'h0,         32'hFFFF_FFBE, 2'b00);
        single("lbu6",  1'b0, 3'b100, 10'h006, 32'h0,         32'h0000_00BE, 2'b00);
        single("lb7",   1'b0, 3'b000, 10'h007, 32'h0,         32'hFFFF_FFAD, 2'b00);
        single("lbu7",  1'b0, 3'b100, 10'h007, 32'h0,         32'h0000_00AD, 2'b00);
        single("lh5",   1'b0, 3'b001, 10'h005, 32'h0,         32'hFFFF_BEEF, 2'b00);
        single("lhu7",  1'b0, 3'b101, 10'h007, 32'h0,         32'h0000_DEAD, 2'b00);
        single("lw3fe", 1'b0, 3'b010, 10'h3FE, 32'h0,         32'h0000_0000, 2'b10);
        single("sw3fe", 1'b1, 3'b010, 10'h3FE, 32'h1234_5678, 32'h0000_0000, 2'b10);
        single("lhu0",  1'b0, 3'b101, 10'h000, 32'h0,         32'h0000_0000, 2'b00);
        single("sw3fc", 1'b1, 3'b010, 10'h3FC, 32'hCAFE_F00D, 32'h0000_0000, 2'b00);
        single("lw3fc", 1'b0, 3'b010, 10'h3FC, 32'h0,         32'hCAFE_F00D, 2'b00);
        single("lb3ff", 1'b0, 3'b000, 10'h3FF, 32'h0,         32'hFFFF_FFCA, 2'b00);
        single("lh3ff", 1'b0, 3'b001, 10'h3FF, 32'h0,         32'h0000_0000, 2'b10);
        single("ld011", 1'b0, 3'b011, 10'h010, 32'h0,         32'h0000_0000, 2'b01);
        single("st100", 1'b1, 3'b100, 10'h010, 32'h5555_5555, 32'h0000_0000, 2'b01);
        single("st101", 1'b1, 3'b101, 10'h010, 32'h5555_5555, 32'h0000_0000, 2'b01);
        single("ld110", 1'b0, 3'b110, 10'h010, 32'h0,         32'h0000_0000, 2'b01);
        single("f3prio", 1'b0, 3'b011, 10'h3FE, 32'h0,        32'h0000_0000, 2'b01);
        single("lw10z", 1'b0, 3'b010, 10'h010, 32'h0,         32'h0000_0000, 2'b00);

        for (int k = 0; k < 4; k++) begin
            single("preload", 1'b1, 3'b010, 10'(10'h010 + 4 * k), words[k], 32'h0, 2'b00);
        end

        // Backpressure: consumer stalled, loads offered every cycle.
        rsp_ready = 1'b0;
        accepts   = 0;
        for (int c = 0; c < 8; c++) begin
            req_valid  = 1'b1;
            req_we     = 1'b0;
            req_funct3 = 3'b010;
            req_addr   = 10'(10'h010 + 4 * accepts);
            #1;
            if (req_ready) accepts++;
            tick();
        end
        req_valid = 1'b0;
        chk("bp accepts", 32'(accepts), 32'd4);
        chk("bp ready low", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("bp drain valid", 32'(rsp_valid), 32'd1);
            chk("bp drain rdata", rsp_rdata, words[k]);
            chk("bp drain err", 32'(rsp_err), 32'd0);
            tick();
        end
        chk("bp empty", 32'(rsp_valid), 32'd0);
        chk("bp ready back", 32'(req_ready), 32'd1);

        // Sustained stream of 16 loads with the consumer always ready.
        for (int c = 0; c < 18; c++) begin
            if (c < 16) begin
                req_valid = 1'b1;
                req_addr  = 10'(10'h010 + 4 * (c % 4));
            end else begin
                req_valid = 1'b0;
            end
            #1;
            if (c < 16) chk("stream ready", 32'(req_ready), 32'd1);
            if (c >= 2) begin
                chk("stream valid", 32'(rsp_valid), 32'd1);
                chk("stream rdata", rsp_rdata, words[(c - 2) % 4]);
            end else begin
                chk("stream lead", 32'(rsp_valid), 32'd0);
            end
            tick();
        end
        chk("stream end", 32'(rsp_valid), 32'd0);

        // Reset with two responses queued and one load in flight.
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            req_valid  = 1'b1;
            req_we     = 1'b0;
            req_funct3 = 3'b010;
            req_addr   = 10'(10'h010 + 4 * c);
            tick();
        end
        rst        = 1'b1;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 10'h010;
        req_wdata  = 32'hBAD0_BAD0;
        #1;
        chk("rst mid rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst mid ready", 32'(req_ready), 32'd0);
        chk("rst mid mem_we", 32'(mem_write_enable), 32'd0);
        chk("rst mid rdata", rsp_rdata, 32'd0);
        chk("rst mid err", 32'(rsp_err), 32'd0);
        tick();
        chk("rst next rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst next ready", 32'(req_ready), 32'd0);
        rst       = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        #1;
        chk("rst release ready", 32'(req_ready), 32'd1);
        chk("rst release valid", 32'(rsp_valid), 32'd0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("rst no stale", 32'(rsp_valid), 32'd0);
        end
        single("lw10 after rst", 1'b0, 3'b010, 10'h010, 32'h0, words[0], 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
